// File: rtl/playseq_unidade_controle_if.sv
// playseq_unidade_controle_if: control/status bundle between the PlaySeq controller and its data flow.
interface playseq_unidade_controle_if;
    logic iniciar, igual, enderecoIgualSequencia, fimE, fimS, tem_jogada;
    logic controle_timeout, controle_timeout_led, pare;
    logic zeraE, zeraS, zeraR, zeraJ, zeraT, zeraT_leds;
    logic carregaE, contaE, contaS, contaJ, contaT, contaT_leds, registraR;
    logic controla_leds, fase_preview, pronto, ganhou, perdeu, db_timeout;

    modport master (
        input  iniciar, igual, enderecoIgualSequencia, fimE, fimS, tem_jogada,
               controle_timeout, controle_timeout_led, pare,
        output zeraE, zeraS, zeraR, zeraJ, zeraT, zeraT_leds,
               carregaE, contaE, contaS, contaJ, contaT, contaT_leds, registraR,
               controla_leds, fase_preview, pronto, ganhou, perdeu, db_timeout
    );

    modport slave (
        output iniciar, igual, enderecoIgualSequencia, fimE, fimS, tem_jogada,
               controle_timeout, controle_timeout_led, pare,
        input  zeraE, zeraS, zeraR, zeraJ, zeraT, zeraT_leds,
               carregaE, contaE, contaS, contaJ, contaT, contaT_leds, registraR,
               controla_leds, fase_preview, pronto, ganhou, perdeu, db_timeout
    );
endinterface

// File: rtl/playseq_unidade_controle.sv
// playseq_unidade_controle: Moore FSM sequencing the PlaySeq data flow (preview, move check, rounds, result).
// Define PLAYSEQ_TIMEOUT_EN to enable the move timeout (contaT, TIMEOUT state, db_timeout).
module playseq_unidade_controle #(
    parameter int ESTADO_W = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    playseq_unidade_controle_if.master bus,
    output logic [ESTADO_W-1:0]        db_estado
);
`ifdef PLAYSEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [4:0] {
        INICIAL      = 5'h00,
        PREPARA      = 5'h01,
        CARREGA      = 5'h02,
        INI_PREVIEW  = 5'h03,
        MOSTRA_LED   = 5'h04,
        APAGA_LED    = 5'h05,
        INTERVALO    = 5'h06,
        PROX_PREVIEW = 5'h07,
        FIM_PREVIEW  = 5'h08,
        ESPERA       = 5'h09,
        REGISTRA     = 5'h0A,
        COMPARA      = 5'h0B,
        PROX_JOGADA  = 5'h0C,
        FIM_RODADA   = 5'h0D,
        ACERTOU      = 5'h0E,
        ERROU        = 5'h0F,
        TIMEOUT      = 5'h10
    } state_t;

    state_t st, nxt;
    logic   pare_q;

    // pare is registered alongside the state so FIM_RODADA's strobes decode flops only
    always_ff @(posedge clock) begin
        if (reset) begin
            st     <= INICIAL;
            pare_q <= 1'b0;
        end else begin
            st     <= nxt;
            pare_q <= bus.pare;
        end
    end

    always_comb begin
        nxt = INICIAL;
        case (st)
            INICIAL:      nxt = bus.iniciar ? PREPARA : INICIAL;
            PREPARA:      nxt = CARREGA;
            CARREGA:      nxt = INI_PREVIEW;
            INI_PREVIEW:  nxt = MOSTRA_LED;
            MOSTRA_LED:   nxt = bus.controle_timeout_led ? APAGA_LED : MOSTRA_LED;
            APAGA_LED:    nxt = INTERVALO;
            INTERVALO:    nxt = !bus.controle_timeout_led ? INTERVALO :
                                bus.enderecoIgualSequencia ? FIM_PREVIEW : PROX_PREVIEW;
            PROX_PREVIEW: nxt = MOSTRA_LED;
            FIM_PREVIEW:  nxt = ESPERA;
            ESPERA:       nxt = bus.tem_jogada ? REGISTRA :
                                (TO_EN && bus.controle_timeout) ? TIMEOUT : ESPERA;
            REGISTRA:     nxt = COMPARA;
            COMPARA:      nxt = !bus.igual ? ERROU :
                                !bus.enderecoIgualSequencia ? PROX_JOGADA :
                                (bus.fimE || bus.fimS) ? ACERTOU : FIM_RODADA;
            PROX_JOGADA:  nxt = ESPERA;
            FIM_RODADA:   nxt = INI_PREVIEW;
            ACERTOU:      nxt = bus.iniciar ? PREPARA : ACERTOU;
            ERROU:        nxt = bus.iniciar ? PREPARA : ERROU;
            TIMEOUT:      nxt = !TO_EN ? INICIAL : bus.iniciar ? PREPARA : TIMEOUT;
            default:      nxt = INICIAL;
        endcase
        bus.zeraE         = st inside {PREPARA, INI_PREVIEW, FIM_PREVIEW};
        bus.zeraS         = st == PREPARA;
        bus.zeraR         = st inside {PREPARA, FIM_PREVIEW};
        bus.zeraJ         = st == PREPARA || (st == FIM_RODADA && pare_q);
        bus.zeraT         = st inside {PREPARA, FIM_PREVIEW, REGISTRA, PROX_JOGADA};
        bus.zeraT_leds    = st inside {PREPARA, INI_PREVIEW, APAGA_LED, PROX_PREVIEW};
        bus.carregaE      = st == CARREGA;
        bus.contaE        = st inside {PROX_PREVIEW, PROX_JOGADA};
        bus.contaS        = st == FIM_RODADA && pare_q;
        bus.contaJ        = st == FIM_RODADA && !pare_q;
        bus.contaT        = TO_EN && st == ESPERA;
        bus.contaT_leds   = st inside {MOSTRA_LED, INTERVALO};
        bus.registraR     = st == REGISTRA;
        bus.controla_leds = st == MOSTRA_LED;
        bus.fase_preview  = st inside {MOSTRA_LED, APAGA_LED, INTERVALO, PROX_PREVIEW};
        bus.pronto        = st inside {ACERTOU, ERROU} || (TO_EN && st == TIMEOUT);
        bus.ganhou        = st == ACERTOU;
        bus.perdeu        = st == ERROU || (TO_EN && st == TIMEOUT);
        bus.db_timeout    = TO_EN && st == TIMEOUT;
    end

    assign db_estado = ESTADO_W'(st);
endmodule

// File: tb/tb_playseq_unidade_controle.sv
// tb_playseq_unidade_controle: random + directed stimulus, scoreboard against a rule-table model of the game controller.
module tb_playseq_unidade_controle;
`ifdef PLAYSEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // stimulus word bits: {reset, iniciar, igual, eis, fimE, fimS, tem_jogada, timeout, timeout_led, pare}
    localparam logic [9:0] R = 10'h200, INI = 10'h100, IG = 10'h080, EIS = 10'h040, FE = 10'h020;
    localparam logic [9:0] FS = 10'h010, TJ = 10'h008, CT = 10'h004, CTL = 10'h002, PA = 10'h001;
    // output vector bits
    localparam logic [18:0] O_ZE = 19'h00001, O_ZS = 19'h00002, O_ZR = 19'h00004, O_ZJ = 19'h00008;
    localparam logic [18:0] O_ZT = 19'h00010, O_ZTL = 19'h00020, O_CE = 19'h00040, O_KE = 19'h00080;
    localparam logic [18:0] O_KS = 19'h00100, O_KJ = 19'h00200, O_KT = 19'h00400, O_KTL = 19'h00800;
    localparam logic [18:0] O_RR = 19'h01000, O_CL = 19'h02000, O_FP = 19'h04000, O_PR = 19'h08000;
    localparam logic [18:0] O_GA = 19'h10000, O_PE = 19'h20000, O_DT = 19'h40000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  db_estado;
    logic [18:0] dut_out;
    int          checks = 0;
    int          failures = 0;
    int          ms = 0;
    logic [23:0] q[$];
    logic [23:0] e;

    playseq_unidade_controle_if bus();
    playseq_unidade_controle #(.ESTADO_W(5)) dut (.clock(clock), .reset(reset), .bus(bus), .db_estado(db_estado));

    always #5 clock = ~clock;

    assign dut_out = {bus.db_timeout, bus.perdeu, bus.ganhou, bus.pronto, bus.fase_preview, bus.controla_leds,
                      bus.registraR, bus.contaT_leds, bus.contaT, bus.contaJ, bus.contaS, bus.contaE,
                      bus.carregaE, bus.zeraT_leds, bus.zeraT, bus.zeraJ, bus.zeraR, bus.zeraS, bus.zeraE};

    function automatic int model_next(int s, logic [9:0] v);
        bit ini = v[8], ig = v[7], eis = v[6], fe = v[5], fs = v[4], tj = v[3], ct = v[2], ctl = v[1];
        if (s == 0)  return ini ? 1 : 0;
        if (s >= 1 && s <= 3) return s + 1;
        if (s == 4)  return ctl ? 5 : 4;
        if (s == 5)  return 6;
        if (s == 6)  return !ctl ? 6 : eis ? 8 : 7;
        if (s == 7)  return 4;
        if (s == 8)  return 9;
        if (s == 9)  return tj ? 10 : (TO_EN && ct) ? 16 : 9;
        if (s == 10) return 11;
        if (s == 11) return !ig ? 15 : !eis ? 12 : (fe || fs) ? 14 : 13;
        if (s == 12) return 9;
        if (s == 13) return 3;
        if (s == 14 || s == 15 || (s == 16 && TO_EN)) return ini ? 1 : s;
        return 0;
    endfunction

    function automatic logic [18:0] model_out(int s, logic p);
        logic [18:0] t [17] = '{19'h0, O_ZE|O_ZS|O_ZR|O_ZJ|O_ZT|O_ZTL, O_CE, O_ZE|O_ZTL, O_FP|O_CL|O_KTL,
                               O_FP|O_ZTL, O_FP|O_KTL, O_FP|O_KE|O_ZTL, O_ZE|O_ZR|O_ZT, TO_EN ? O_KT : 19'h0,
                               O_RR|O_ZT, 19'h0, O_KE|O_ZT, p ? (O_KS|O_ZJ) : O_KJ, O_PR|O_GA, O_PR|O_PE,
                               TO_EN ? (O_PR|O_PE|O_DT) : 19'h0};
        return (s >= 0 && s <= 16) ? t[s] : 19'h0;
    endfunction

    task automatic step(input logic [9:0] v);
        @(negedge clock);
        {reset, bus.iniciar, bus.igual, bus.enderecoIgualSequencia, bus.fimE, bus.fimS,
         bus.tem_jogada, bus.controle_timeout, bus.controle_timeout_led, bus.pare} = v;
        ms = v[9] ? 0 : model_next(ms, v);
        q.push_back({5'(ms), model_out(ms, v[0])});
    endtask

    task automatic to_espera();
        step(R); step(R); step(INI); step(0); step(0); step(0);
        step(CTL); step(0); step(CTL); step(0);
        step(CTL); step(0); step(CTL | EIS); step(0);
    endtask

    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 2;
            if (db_estado !== e[23:19]) begin
                failures++;
                $display("FAIL state t=%0t got=%h exp=%h", $time, db_estado, e[23:19]);
            end
            if (dut_out !== e[18:0]) begin
                failures++;
                $display("FAIL outputs t=%0t state=%h got=%h exp=%h", $time, e[23:19], dut_out, e[18:0]);
            end
        end
    end

    initial begin
        {bus.iniciar, bus.igual, bus.enderecoIgualSequencia, bus.fimE, bus.fimS,
         bus.tem_jogada, bus.controle_timeout, bus.controle_timeout_led, bus.pare} = '0;
        // win with simultaneous move/timeout, hold, restart, then reset mid-interval
        to_espera();
        step(TJ | CT); step(0); step(IG | EIS | FE);
        repeat (10) step(0);
        step(INI); step(0); step(0); step(0); step(CTL); step(0); step(R);
        // lose, then replay same length, then grow
        to_espera(); step(TJ); step(0); step(0); step(0); step(R);
        to_espera(); step(TJ); step(0); step(IG | EIS); step(0);
        step(0); step(CTL); step(0); step(CTL | EIS); step(0);
        step(TJ); step(PA); step(IG | EIS | PA); step(0);
        // timeout after an intermediate move
        to_espera(); step(TJ | CT); step(0); step(IG); step(0);
        repeat (100) step(CT);
        step(INI);
        // win via fimS then reset in terminal state
        to_espera(); step(TJ); step(0); step(IG | EIS | FS); step(0); step(R);
        repeat (3000) begin
            logic [9:0] v;
            v = 10'($urandom);
            v[9] = ($urandom_range(0, 49) == 0);
            step(v);
        end
        step(R);
        @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
